// File: rtl/draw_obstacle.sv
// draw_obstacle
// Overlay stage that sits between draw_background and MouseDisplay. It draws
// one square obstacle that bounces inside the arena box, moving once per
// frame, and raises a sticky hit flag when the mouse cursor lands on it.
//
// Ports:
//   pclk, rst          pixel clock, asynchronous active-high reset
//   game_on            game running enable (level)
//   hcount_in/vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in
//                      incoming timing bus
//   rgb_in             background pixel
//   xpos, ypos         mouse cursor position (quasi-static, used on ticks only)
//   *_out              timing bus delayed by one pclk
//   rgb_out            composited pixel, one pclk latency
//   hit                sticky collision flag
//   obstacle_x/_y      current top-left corner of the obstacle
module draw_obstacle #(
  parameter logic [11:0] TOP_V_LINE    = 12'd317,
  parameter logic [11:0] BOTTOM_V_LINE = 12'd617,
  parameter logic [11:0] LEFT_H_LINE   = 12'd361,
  parameter logic [11:0] RIGHT_H_LINE  = 12'd661,
  parameter logic [11:0] SIZE          = 12'd32,
  parameter logic [11:0] SPEED_X       = 12'd2,
  parameter logic [11:0] SPEED_Y       = 12'd1,
  parameter logic [11:0] START_X       = 12'd400,
  parameter logic [11:0] START_Y       = 12'd350,
  parameter logic [11:0] COLOR         = 12'hF00
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        game_on,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        hit,
  output logic [11:0] obstacle_x,
  output logic [11:0] obstacle_y
);

  typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;

  state_t      state, state_nxt;
  logic        dir_x, dir_y;          // 1 = moving in the + direction
  logic        dir_x_nxt, dir_y_nxt;
  logic [11:0] x_nxt, y_nxt;
  logic [11:0] x_step, y_step;
  logic        dir_x_step, dir_y_step;
  logic        vblnk_prev;
  logic        tick;
  logic        mouse_on, pixel_on;
  logic [11:0] rgb_nxt;

  // One pulse per frame on the rising edge of vertical blanking, so the
  // obstacle only ever moves while nothing is being displayed.
  assign tick = vblnk_in & ~vblnk_prev;

  assign mouse_on = (xpos >= obstacle_x) && (xpos <= obstacle_x + SIZE - 12'd1) &&
                    (ypos >= obstacle_y) && (ypos <= obstacle_y + SIZE - 12'd1);

  assign pixel_on = (hcount_in >= obstacle_x) && (hcount_in <= obstacle_x + SIZE - 12'd1) &&
                    (vcount_in >= obstacle_y) && (vcount_in <= obstacle_y + SIZE - 12'd1);

  assign hit = (state == HIT);

  // Candidate position for the next frame. Moving in the - direction the
  // clamp is tested before subtracting so the unsigned value never wraps.
  always_comb begin
    x_step     = obstacle_x;
    dir_x_step = dir_x;
    if (dir_x) begin
      if (obstacle_x + SPEED_X >= RIGHT_H_LINE - SIZE) begin
        x_step     = RIGHT_H_LINE - SIZE;
        dir_x_step = 1'b0;
      end else begin
        x_step = obstacle_x + SPEED_X;
      end
    end else begin
      if (obstacle_x <= LEFT_H_LINE + SPEED_X) begin
        x_step     = LEFT_H_LINE;
        dir_x_step = 1'b1;
      end else begin
        x_step = obstacle_x - SPEED_X;
      end
    end

    y_step     = obstacle_y;
    dir_y_step = dir_y;
    if (dir_y) begin
      if (obstacle_y + SPEED_Y >= BOTTOM_V_LINE - SIZE) begin
        y_step     = BOTTOM_V_LINE - SIZE;
        dir_y_step = 1'b0;
      end else begin
        y_step = obstacle_y + SPEED_Y;
      end
    end else begin
      if (obstacle_y <= TOP_V_LINE + SPEED_Y) begin
        y_step     = TOP_V_LINE;
        dir_y_step = 1'b1;
      end else begin
        y_step = obstacle_y - SPEED_Y;
      end
    end
  end

  // Next-state logic. Dropping game_on wins over everything, including a
  // tick in the same cycle, and returns the obstacle to its start point.
  always_comb begin
    state_nxt = state;
    x_nxt     = obstacle_x;
    y_nxt     = obstacle_y;
    dir_x_nxt = dir_x;
    dir_y_nxt = dir_y;
    if (!game_on) begin
      state_nxt = IDLE;
      x_nxt     = START_X;
      y_nxt     = START_Y;
      dir_x_nxt = 1'b1;
      dir_y_nxt = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          x_nxt     = START_X;
          y_nxt     = START_Y;
          dir_x_nxt = 1'b1;
          dir_y_nxt = 1'b1;
          if (tick) state_nxt = RUN;
        end
        RUN: begin
          if (tick) begin
            if (mouse_on) begin
              state_nxt = HIT;
            end else begin
              x_nxt     = x_step;
              y_nxt     = y_step;
              dir_x_nxt = dir_x_step;
              dir_y_nxt = dir_y_step;
            end
          end
        end
        HIT:     state_nxt = HIT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Game state and obstacle position registers.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      obstacle_x <= START_X;
      obstacle_y <= START_Y;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      vblnk_prev <= 1'b0;
    end else begin
      state      <= state_nxt;
      obstacle_x <= x_nxt;
      obstacle_y <= y_nxt;
      dir_x      <= dir_x_nxt;
      dir_y      <= dir_y_nxt;
      vblnk_prev <= vblnk_in;
    end
  end

  // Pixel compositing: blanking forces black, otherwise the obstacle is
  // painted over the background whenever the game is not idle.
  always_comb begin
    rgb_nxt = rgb_in;
    if (hblnk_in || vblnk_in) begin
      rgb_nxt = 12'h000;
    end else if ((state != IDLE) && pixel_on) begin
      rgb_nxt = COLOR;
    end
  end

  // One-cycle pipeline for the timing bus and the composited pixel.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_out <= 12'd0;
      vcount_out <= 12'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      hblnk_out  <= hblnk_in;
      vblnk_out  <= vblnk_in;
      rgb_out    <= rgb_nxt;
    end
  end

endmodule

// File: tb/tb_draw_obstacle.sv
// tb_draw_obstacle
// Self-checking bench for draw_obstacle. A behavioural model of the bouncing
// obstacle runs alongside the DUT every cycle; directed scenarios cover reset,
// latency, the draw window, collision, idle return and a right-edge bounce
// (second instance started near the right wall), followed by randomized frames.
module tb_draw_obstacle;

  localparam int TOP = 317, BOTTOM = 617, LEFT = 361, RIGHT = 661;
  localparam int SIZE = 32, SPX = 2, SPY = 1, SX = 400, SY = 350;
  localparam logic [11:0] COLOR = 12'hF00;
  localparam int MODE_IDLE = 0, MODE_RUN = 1, MODE_HIT = 2;

  logic        pclk = 1'b0;
  logic        rst;
  logic        game_on;
  logic [11:0] hcount_in, vcount_in, rgb_in, xpos, ypos;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;

  logic [11:0] hcount_out, vcount_out, rgb_out, obstacle_x, obstacle_y;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out, hit;

  logic [11:0] b_hcount_out, b_vcount_out, b_rgb_out, b_obstacle_x, b_obstacle_y;
  logic        b_hsync_out, b_vsync_out, b_hblnk_out, b_vblnk_out, b_hit;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_mode, m_x, m_y, m_dx, m_dy;
  bit m_prev_vblnk;
  int hit_frames;

  always #5 pclk = ~pclk;

  draw_obstacle u_dut (
    .pclk(pclk), .rst(rst), .game_on(game_on),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .hit(hit), .obstacle_x(obstacle_x), .obstacle_y(obstacle_y)
  );

  draw_obstacle #(.START_X(12'd625)) u_dut_b (
    .pclk(pclk), .rst(rst), .game_on(game_on),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .hcount_out(b_hcount_out), .vcount_out(b_vcount_out),
    .hsync_out(b_hsync_out), .vsync_out(b_vsync_out), .hblnk_out(b_hblnk_out), .vblnk_out(b_vblnk_out),
    .rgb_out(b_rgb_out), .hit(b_hit), .obstacle_x(b_obstacle_x), .obstacle_y(b_obstacle_y)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  function automatic bit inBox(input int px, input int py, input int bx, input int by);
    return (px >= bx) && (px < bx + SIZE) && (py >= by) && (py < by + SIZE);
  endfunction

  // One axis of the bounce rule, in plain integer arithmetic.
  task automatic stepAxis(input int p, input int d, input int lo, input int hi, input int spd,
                          output int np, output int nd);
    np = p; nd = d;
    if (d > 0) begin
      if (p + spd >= hi - SIZE) begin np = hi - SIZE; nd = -1; end
      else np = p + spd;
    end else begin
      if (p <= lo + spd) begin np = lo; nd = 1; end
      else np = p - spd;
    end
  endtask

  task automatic modelReset();
    m_mode = MODE_IDLE; m_x = SX; m_y = SY; m_dx = 1; m_dy = 1; m_prev_vblnk = 1'b0;
  endtask

  // Apply the current inputs for one clock and check every output of u_dut
  // against the model's prediction.
  task automatic applyStimulus();
    logic [31:0] exp_timing;
    logic [11:0] exp_rgb;
    int n_mode, n_x, n_y, n_dx, n_dy;
    bit tick;
    exp_timing = {4'd0, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    if (hblnk_in || vblnk_in) exp_rgb = 12'h000;
    else if (m_mode != MODE_IDLE && inBox(int'(hcount_in), int'(vcount_in), m_x, m_y)) exp_rgb = COLOR;
    else exp_rgb = rgb_in;
    tick = vblnk_in && !m_prev_vblnk;
    n_mode = m_mode; n_x = m_x; n_y = m_y; n_dx = m_dx; n_dy = m_dy;
    if (!game_on) begin
      n_mode = MODE_IDLE; n_x = SX; n_y = SY; n_dx = 1; n_dy = 1;
    end else if (m_mode == MODE_IDLE) begin
      if (tick) n_mode = MODE_RUN;
    end else if (m_mode == MODE_RUN && tick) begin
      if (inBox(int'(xpos), int'(ypos), m_x, m_y)) n_mode = MODE_HIT;
      else begin
        stepAxis(m_x, m_dx, LEFT, RIGHT, SPX, n_x, n_dx);
        stepAxis(m_y, m_dy, TOP, BOTTOM, SPY, n_y, n_dy);
      end
    end
    @(posedge pclk);
    #1;
    checkOutput("timing", {4'd0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, exp_timing);
    checkOutput("rgb", 32'(rgb_out), 32'(exp_rgb));
    checkOutput("hit", 32'(hit), 32'(n_mode == MODE_HIT));
    checkOutput("obs_x", 32'(obstacle_x), 32'(n_x));
    checkOutput("obs_y", 32'(obstacle_y), 32'(n_y));
    m_mode = n_mode; m_x = n_x; m_y = n_y; m_dx = n_dx; m_dy = n_dy;
    m_prev_vblnk = vblnk_in;
  endtask

  // Short synthetic frames: 40 cycles, vertical blanking on the last 8.
  // In wild mode the mouse, game_on, blanking and pixel positions are randomized.
  task automatic runFrames(input int frames, input bit wild);
    for (int f = 0; f < frames; f++) begin
      if (wild) begin
        if (m_mode == MODE_HIT) hit_frames++;
        else hit_frames = 0;
        if (hit_frames > 3) game_on = 1'b0;
        else game_on = ($urandom_range(0, 199) != 0);
        if ($urandom_range(0, 149) == 0) begin
          xpos = 12'(m_x + $urandom_range(0, SIZE + 8) - 4);
          ypos = 12'(m_y + $urandom_range(0, SIZE + 8) - 4);
        end else begin
          xpos = 12'd0; ypos = 12'd0;
        end
      end
      for (int c = 0; c < 40; c++) begin
        vblnk_in = (c >= 32);
        hblnk_in = wild ? ((c % 8) >= 6) : 1'b0;
        hsync_in = 1'($urandom_range(0, 1));
        vsync_in = 1'($urandom_range(0, 1));
        rgb_in   = 12'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          hcount_in = 12'(m_x + $urandom_range(0, SIZE + 7) - 4);
          vcount_in = 12'(m_y + $urandom_range(0, SIZE + 7) - 4);
        end else begin
          hcount_in = 12'($urandom);
          vcount_in = 12'($urandom);
        end
        if (wild && c == 32 && $urandom_range(0, 99) == 0) game_on = 1'b0;
        applyStimulus();
      end
    end
  endtask

  task automatic quietInputs();
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    hcount_in = 12'd0; vcount_in = 12'd0; rgb_in = 12'h123;
  endtask

  initial begin
    rst = 1'b1; game_on = 1'b0; xpos = 12'd0; ypos = 12'd0; hit_frames = 0;
    quietInputs();
    modelReset();
    repeat (3) @(posedge pclk);
    #1;
    checkOutput("rst_rgb", 32'(rgb_out), 32'h0);
    checkOutput("rst_hcount", 32'(hcount_out), 32'h0);
    checkOutput("rst_x", 32'(obstacle_x), 32'd400);
    checkOutput("rst_y", 32'(obstacle_y), 32'd350);
    checkOutput("rst_hit", 32'(hit), 32'h0);
    @(negedge pclk);
    rst = 1'b0;
    #1;

    // Latency and idle: obstacle pixel position but game off -> background.
    hcount_in = 12'd100; hsync_in = 1'b1; rgb_in = 12'h5A5;
    applyStimulus();
    checkOutput("lat_hcount", 32'(hcount_out), 32'd100);
    checkOutput("lat_hsync", 32'(hsync_out), 32'd1);
    checkOutput("lat_rgb", 32'(rgb_out), 32'h5A5);
    hcount_in = 12'd400; vcount_in = 12'd350; hsync_in = 1'b0; rgb_in = 12'h0A0;
    applyStimulus();
    checkOutput("idle_nodraw", 32'(rgb_out), 32'h0A0);

    // Enter RUN at the start point, then probe the draw window.
    game_on = 1'b1;
    runFrames(1, 1'b0);
    quietInputs();
    hcount_in = 12'd400; vcount_in = 12'd350; rgb_in = 12'h00F;
    applyStimulus();
    checkOutput("draw_corner", 32'(rgb_out), 32'hF00);
    hcount_in = 12'd431; vcount_in = 12'd381;
    applyStimulus();
    checkOutput("draw_last", 32'(rgb_out), 32'hF00);
    hcount_in = 12'd432; vcount_in = 12'd350;
    applyStimulus();
    checkOutput("draw_past", 32'(rgb_out), 32'h00F);
    hcount_in = 12'd410; hblnk_in = 1'b1;
    applyStimulus();
    checkOutput("draw_blank", 32'(rgb_out), 32'h000);

    // Collision on the next tick freezes the obstacle.
    xpos = 12'd410; ypos = 12'd360;
    runFrames(1, 1'b0);
    checkOutput("col_hit", 32'(hit), 32'd1);
    runFrames(3, 1'b0);
    checkOutput("col_hold_x", 32'(obstacle_x), 32'd400);
    checkOutput("col_hold_y", 32'(obstacle_y), 32'd350);
    checkOutput("col_hold_hit", 32'(hit), 32'd1);

    // Drop game_on: back to idle on the next clock, then resume.
    game_on = 1'b0; xpos = 12'd0; ypos = 12'd0;
    quietInputs();
    applyStimulus();
    checkOutput("idle_hit", 32'(hit), 32'd0);
    checkOutput("idle_x", 32'(obstacle_x), 32'd400);
    game_on = 1'b1;
    runFrames(2, 1'b0);
    checkOutput("resume_x", 32'(obstacle_x), 32'd402);
    checkOutput("resume_y", 32'(obstacle_y), 32'd351);

    // Right-edge bounce on the instance started at x=625.
    rst = 1'b1;
    #2;
    modelReset();
    checkOutput("b_rst_x", 32'(b_obstacle_x), 32'd625);
    @(negedge pclk);
    rst = 1'b0;
    game_on = 1'b1;
    runFrames(1, 1'b0);
    runFrames(1, 1'b0);
    checkOutput("bounce_1", 32'(b_obstacle_x), 32'd627);
    runFrames(1, 1'b0);
    checkOutput("bounce_clamp", 32'(b_obstacle_x), 32'd629);
    runFrames(1, 1'b0);
    checkOutput("bounce_back", 32'(b_obstacle_x), 32'd627);

    // Randomized frames against the model.
    runFrames(900, 1'b1);

    // Asynchronous reset mid-line clears outputs without a clock edge.
    game_on = 1'b1; vblnk_in = 1'b0; hblnk_in = 1'b0; hcount_in = 12'd55;
    applyStimulus();
    rst = 1'b1;
    #2;
    checkOutput("arst_hcount", 32'(hcount_out), 32'h0);
    checkOutput("arst_rgb", 32'(rgb_out), 32'h0);
    checkOutput("arst_x", 32'(obstacle_x), 32'd400);
    checkOutput("arst_y", 32'(obstacle_y), 32'd350);
    checkOutput("arst_hit", 32'(hit), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
